// File: rtl/myip_dht11_s00_axi_slave.sv
// AXI4-Lite register slave for the DHT11 IP: four 32-bit registers, reg0 drives ctrl_reg.
// Define DHT11_HWDATA_EN to make reg2/reg3 read-only sensor sample and sample counter.
module myip_dht11_s00_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     ctrl_reg,
    input  logic [15:0]                     hw_humidity,
    input  logic [15:0]                     hw_temperature,
    input  logic                            hw_data_valid
);

    logic [31:0] reg_q [4];
    logic [31:0] reg_d [4];
    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_accept;
    logic        rd_accept;
    logic        wr_allowed;
    logic [1:0]  wr_idx;
    logic [1:0]  rd_idx;
    logic        unused_bits;

    assign wr_idx = S_AXI_AWADDR[3:2];
    assign rd_idx = S_AXI_ARADDR[3:2];

`ifdef DHT11_HWDATA_EN
    assign wr_allowed  = ~wr_idx[1];
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign wr_allowed  = 1'b1;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           hw_humidity, hw_temperature, hw_data_valid};
`endif

    assign wr_accept = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    assign rd_accept = S_AXI_ARVALID & ~rvalid_q & ~arready_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            reg_d[i] = reg_q[i];
        end
        awready_d = wr_accept;
        arready_d = rd_accept;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        if (awready_q) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Read data is snapshotted at accept so a same-edge write is not visible.
        if (rd_accept) begin
            rdata_d = reg_q[rd_idx];
        end
        if (arready_q) begin
            rvalid_d = 1'b1;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        if (wr_accept) begin
            bresp_d = wr_allowed ? 2'b00 : 2'b10;
            if (wr_allowed) begin
                for (int b = 0; b < 4; b++) begin
                    if (S_AXI_WSTRB[b]) begin
                        reg_d[wr_idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                    end
                end
            end
        end

`ifdef DHT11_HWDATA_EN
        if (hw_data_valid) begin
            reg_d[2] = {hw_humidity, hw_temperature};
            reg_d[3] = reg_q[3] + 32'd1;
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                reg_q[i] <= 32'd0;
            end
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                reg_q[i] <= reg_d[i];
            end
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign ctrl_reg      = reg_q[0];

endmodule

// File: tb/tb_myip_dht11_s00_axi_slave.sv
// Bench for myip_dht11_s00_axi_slave: directed scenarios plus randomized traffic checked
// every cycle against a register-map/handshake model. Honors DHT11_HWDATA_EN.
module tb_myip_dht11_s00_axi_slave;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN = 1'b0;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b1;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b1;
    logic [31:0] ctrl_reg;
    logic [15:0] hw_humidity = '0;
    logic [15:0] hw_temperature = '0;
    logic        hw_data_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    bit wr_done = 0;
    bit rd_done = 0;

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    myip_dht11_s00_axi_slave dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl_reg(ctrl_reg), .hw_humidity(hw_humidity),
        .hw_temperature(hw_temperature), .hw_data_valid(hw_data_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for handshake t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] m_mem [4] = '{default: 32'd0};
    bit          e_awready = 0, e_bvalid = 0, e_arready = 0, e_rvalid = 0;
    logic [1:0]  e_bresp = 0;
    logic [31:0] e_rdata = 0;
    bit          p_rstn = 0, p_awv = 0, p_wv = 0, p_arv = 0, p_bready = 0, p_rready = 0, p_hwv = 0;
    logic [3:0]  p_awaddr = 0, p_araddr = 0, p_wstrb = 0;
    logic [31:0] p_wdata = 0, p_hwval = 0;

    always @(negedge S_AXI_ACLK) begin
        bit wr_acc, rd_acc;
        logic [31:0] mask;
        int idx;
        if (!p_rstn) begin
            m_mem = '{default: 32'd0};
            e_awready = 0; e_bvalid = 0; e_arready = 0; e_rvalid = 0;
            e_bresp = 0; e_rdata = 0;
        end else begin
            wr_acc = p_awv && p_wv && !e_bvalid && !e_awready;
            rd_acc = p_arv && !e_rvalid && !e_arready;
            e_bvalid = e_awready || (e_bvalid && !p_bready);
            e_rvalid = e_arready || (e_rvalid && !p_rready);
            if (rd_acc) e_rdata = m_mem[p_araddr[3:2]];
            e_awready = wr_acc;
            e_arready = rd_acc;
            if (wr_acc) begin
                idx = int'(p_awaddr[3:2]);
`ifdef DHT11_HWDATA_EN
                if (idx >= 2) e_bresp = 2'b10;
                else begin
`endif
                    e_bresp = 2'b00;
                    mask = {{8{p_wstrb[3]}}, {8{p_wstrb[2]}}, {8{p_wstrb[1]}}, {8{p_wstrb[0]}}};
                    m_mem[idx] = (m_mem[idx] & ~mask) | (p_wdata & mask);
`ifdef DHT11_HWDATA_EN
                end
`endif
            end
`ifdef DHT11_HWDATA_EN
            if (p_hwv) begin
                m_mem[2] = p_hwval;
                m_mem[3] = m_mem[3] + 1;
            end
`endif
        end
        check("awready", {31'd0, S_AXI_AWREADY}, {31'd0, e_awready});
        check("wready", {31'd0, S_AXI_WREADY}, {31'd0, e_awready});
        check("bvalid", {31'd0, S_AXI_BVALID}, {31'd0, e_bvalid});
        check("arready", {31'd0, S_AXI_ARREADY}, {31'd0, e_arready});
        check("rvalid", {31'd0, S_AXI_RVALID}, {31'd0, e_rvalid});
        check("ctrl_reg", ctrl_reg, m_mem[0]);
        if (e_bvalid) check("bresp", {30'd0, S_AXI_BRESP}, {30'd0, e_bresp});
        if (e_rvalid) begin
            check("rdata", S_AXI_RDATA, e_rdata);
            check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        end
        p_rstn = S_AXI_ARESETN; p_awv = S_AXI_AWVALID; p_wv = S_AXI_WVALID;
        p_arv = S_AXI_ARVALID; p_bready = S_AXI_BREADY; p_rready = S_AXI_RREADY;
        p_awaddr = S_AXI_AWADDR; p_araddr = S_AXI_ARADDR; p_wstrb = S_AXI_WSTRB;
        p_wdata = S_AXI_WDATA; p_hwv = hw_data_valid; p_hwval = {hw_humidity, hw_temperature};
    end

    // ---------------- master tasks ----------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lag, output logic [1:0] resp);
        int n;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = (w_lag == 0);
        n = 0;
        while (!S_AXI_AWREADY && n < 60) begin
            tick();
            n++;
            if (n >= w_lag) S_AXI_WVALID = 1'b1;
        end
        if (!S_AXI_AWREADY) timeout("awready");
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 60) begin tick(); n++; end
        if (!S_AXI_BVALID) timeout("bvalid");
        resp = S_AXI_BRESP;
        n = 0;
        while (S_AXI_BVALID && n < 300) begin tick(); n++; end
        if (S_AXI_BVALID) timeout("bvalid_drop");
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        S_AXI_ARADDR = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 60) begin tick(); n++; end
        if (!S_AXI_ARREADY) timeout("arready");
        tick();
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 60) begin tick(); n++; end
        if (!S_AXI_RVALID) timeout("rvalid");
        data = S_AXI_RDATA;
        n = 0;
        while (S_AXI_RVALID && n < 300) begin tick(); n++; end
        if (S_AXI_RVALID) timeout("rvalid_drop");
    endtask

    // ---------------- scenario driver ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int aw_pulses, bv_cycles, n;

        // reset held 20 cycles
        repeat (20) tick();
        check("t1_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        check("t1_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        check("t1_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        check("t1_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        S_AXI_ARESETN = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), d);
            check("t1_read_zero", d, 32'd0);
        end

        // plain writes and read-back
        for (int a = 0; a < 4; a++) begin
            axi_write(4'(a * 4), 32'(a + 1), 4'hF, 0, r);
`ifdef DHT11_HWDATA_EN
            check("t2_bresp", {30'd0, r}, (a >= 2) ? 32'd2 : 32'd0);
`else
            check("t2_bresp", {30'd0, r}, 32'd0);
`endif
        end
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), d);
`ifdef DHT11_HWDATA_EN
            check("t2_read", d, (a >= 2) ? 32'd0 : 32'(a + 1));
`else
            check("t2_read", d, 32'(a + 1));
`endif
        end

        // byte-lane strobe
        axi_write(4'h0, 32'd0, 4'hF, 0, r);
        axi_write(4'h0, 32'hAABBCCDD, 4'b0010, 0, r);
        axi_read(4'h0, d);
        check("t3_strobe_read", d, 32'h0000CC00);
        check("t3_ctrl_reg", ctrl_reg, 32'h0000CC00);

        // AW leads W by 3 cycles, BREADY held low
        S_AXI_BREADY = 1'b0;
        aw_pulses = 0;
        bv_cycles = 0;
        fork
            axi_write(4'h4, 32'h2, 4'hF, 3, r);
            begin
                n = 0;
                while (!S_AXI_BVALID && n < 60) begin
                    tick();
                    if (S_AXI_AWREADY) aw_pulses++;
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    if (S_AXI_BVALID) bv_cycles++;
                    if (i < 4) tick();
                end
                S_AXI_BREADY = 1'b1;
            end
        join
        check("t4_aw_pulses", 32'(aw_pulses), 32'd1);
        check("t4_bvalid_held", 32'(bv_cycles), 32'd5);

        // same-edge write and read of reg1
        fork
            axi_write(4'h4, 32'h55, 4'hF, 0, r);
            axi_read(4'h4, d);
        join
        check("t5_same_cycle_old", d, 32'h2);
        axi_read(4'h4, d);
        check("t5_after_write", d, 32'h55);

`ifdef DHT11_HWDATA_EN
        hw_humidity = 16'h3700;
        hw_temperature = 16'h1A05;
        hw_data_valid = 1'b1;
        tick();
        hw_data_valid = 1'b0;
        axi_read(4'h8, d);
        check("t6_sample", d, 32'h37001A05);
        axi_read(4'hC, d);
        check("t6_count", d, 32'd1);
        axi_write(4'h8, 32'hDEADBEEF, 4'hF, 0, r);
        check("t6_slverr", {30'd0, r}, 32'd2);
        axi_read(4'h8, d);
        check("t6_unchanged", d, 32'h37001A05);
`endif

        // randomized traffic; the per-cycle model does the checking
        fork
            begin
                logic [1:0] rr;
                for (int i = 0; i < 120; i++) begin
                    axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                              $urandom_range(0, 3), rr);
                    repeat ($urandom_range(0, 3)) tick();
                end
                wr_done = 1;
            end
            begin
                logic [31:0] dd;
                for (int i = 0; i < 120; i++) begin
                    axi_read(4'($urandom_range(0, 15)), dd);
                    repeat ($urandom_range(0, 3)) tick();
                end
                rd_done = 1;
            end
            begin
                int k;
                k = 0;
                while (!(wr_done && rd_done) && k < 20000) begin
                    tick();
                    S_AXI_BREADY = ($urandom_range(0, 3) != 0);
                    S_AXI_RREADY = ($urandom_range(0, 3) != 0);
                    hw_data_valid = ($urandom_range(0, 9) == 0);
                    hw_humidity = 16'($urandom);
                    hw_temperature = 16'($urandom);
                    k++;
                end
                if (!(wr_done && rd_done)) timeout("random_phase");
            end
        join
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        hw_data_valid = 1'b0;
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
